// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle MIPS-style control FSM.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StRExec  = 4'd6,
        StRWb    = 4'd7,
        StIExec  = 4'd8,
        StIWb    = 4'd9,
        StBranch = 4'd10,
        StJump   = 4'd11
    } state_e;

    localparam logic [5:0] OpR    = 6'b000000;
    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpAndi = 6'b001100;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpBne  = 6'b000101;
    localparam logic [5:0] OpJ    = 6'b000010;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;
    localparam logic [1:0] AluAnd   = 2'b11;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: state register plus a Moore-style output decode,
// with memory-ready qualification in FETCH/MEMRD/MEMWR.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned OP_W   = 6,
    parameter bit          MEM_HS = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            mem_ready,
    output logic            PCWrite,
    output logic            PCWriteCond_Beq,
    output logic            PCWriteCond_Bne,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic            MemtoReg,
    output logic            RegDst,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUOp,
    output logic [1:0]      PCSource,
    output logic            illegal_op,
    output logic [3:0]      state_o
);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q;
    logic              mem_ok;

    // Opcodes are compared zero-extended to the configured opcode width.
    function automatic logic is_op(input logic [OP_W-1:0] v, input logic [5:0] c);
        return v == OP_W'(c);
    endfunction

    assign mem_ok  = MEM_HS ? mem_ready : 1'b1;
    assign state_o = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                op_q <= opcode;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        PCWrite         = 1'b0;
        PCWriteCond_Beq = 1'b0;
        PCWriteCond_Bne = 1'b0;
        IorD            = 1'b0;
        MemRead         = 1'b0;
        MemWrite        = 1'b0;
        IRWrite         = 1'b0;
        MemtoReg        = 1'b0;
        RegDst          = 1'b0;
        RegWrite        = 1'b0;
        ALUSrcA         = 1'b0;
        ALUSrcB         = SrcBReg;
        ALUOp           = AluAdd;
        PCSource        = PcSrcAlu;
        illegal_op      = 1'b0;

        unique case (state_q)
            StFetch: begin
                MemRead = 1'b1;
                ALUSrcB = SrcBFour;
                IRWrite = mem_ok;
                PCWrite = mem_ok;
                if (mem_ok) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                ALUSrcB = SrcBImmSh;
                if (is_op(opcode, OpLw) || is_op(opcode, OpSw)) begin
                    state_d = StMemAdr;
                end else if (is_op(opcode, OpR)) begin
                    state_d = StRExec;
                end else if (is_op(opcode, OpAddi) || is_op(opcode, OpAndi)) begin
                    state_d = StIExec;
                end else if (is_op(opcode, OpBeq) || is_op(opcode, OpBne)) begin
                    state_d = StBranch;
                end else if (is_op(opcode, OpJ)) begin
                    state_d = StJump;
                end else begin
                    illegal_op = 1'b1;
                    state_d    = StFetch;
                end
            end
            StMemAdr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SrcBImm;
                state_d = is_op(op_q, OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ok) begin
                    state_d = StMemWb;
                end
            end
            StMemWr: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ok) begin
                    state_d = StFetch;
                end
            end
            StMemWb: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = StFetch;
            end
            StRExec: begin
                ALUSrcA = 1'b1;
                ALUOp   = AluFunct;
                state_d = StRWb;
            end
            StRWb: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = StFetch;
            end
            StIExec: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SrcBImm;
                ALUOp   = is_op(op_q, OpAndi) ? AluAnd : AluAdd;
                state_d = StIWb;
            end
            StIWb: begin
                RegWrite = 1'b1;
                state_d  = StFetch;
            end
            StBranch: begin
                ALUSrcA         = 1'b1;
                ALUOp           = AluSub;
                PCSource        = PcSrcAluOut;
                PCWriteCond_Beq = is_op(op_q, OpBeq);
                PCWriteCond_Bne = is_op(op_q, OpBne);
                state_d         = StFetch;
            end
            StJump: begin
                PCWrite  = 1'b1;
                PCSource = PcSrcJump;
                state_d  = StFetch;
            end
            // Unused encodings recover to FETCH with every output held low.
            default: state_d = StFetch;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: one DUT with the memory handshake,
// one with it disabled; every cycle's full output vector is checked.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, beq, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, aluop, pcsrc;
        logic       ill;
    } obs_t;

    logic       clk, rst_a, rst_b, mem_ready;
    logic [5:0] opcode;
    obs_t       obs_a, obs_b;
    obs_t       exp_q[$];
    logic [5:0] held;
    logic       use_b;
    int         checks, errors;

    multicycle_control #(.OP_W(6), .MEM_HS(1'b1)) dut_a (
        .clk(clk), .reset(rst_a), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(obs_a.pcw), .PCWriteCond_Beq(obs_a.beq), .PCWriteCond_Bne(obs_a.bne),
        .IorD(obs_a.iord), .MemRead(obs_a.mrd), .MemWrite(obs_a.mwr), .IRWrite(obs_a.irw),
        .MemtoReg(obs_a.m2r), .RegDst(obs_a.rdst), .RegWrite(obs_a.rw),
        .ALUSrcA(obs_a.srca), .ALUSrcB(obs_a.srcb), .ALUOp(obs_a.aluop),
        .PCSource(obs_a.pcsrc), .illegal_op(obs_a.ill), .state_o(obs_a.st)
    );

    multicycle_control #(.OP_W(6), .MEM_HS(1'b0)) dut_b (
        .clk(clk), .reset(rst_b), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(obs_b.pcw), .PCWriteCond_Beq(obs_b.beq), .PCWriteCond_Bne(obs_b.bne),
        .IorD(obs_b.iord), .MemRead(obs_b.mrd), .MemWrite(obs_b.mwr), .IRWrite(obs_b.irw),
        .MemtoReg(obs_b.m2r), .RegDst(obs_b.rdst), .RegWrite(obs_b.rw),
        .ALUSrcA(obs_b.srca), .ALUSrcB(obs_b.srcb), .ALUOp(obs_b.aluop),
        .PCSource(obs_b.pcsrc), .illegal_op(obs_b.ill), .state_o(obs_b.st)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic legal(input logic [5:0] op);
        return op inside {OpR, OpLw, OpSw, OpAddi, OpAndi, OpBeq, OpBne, OpJ};
    endfunction

    // Expected control word for a state, taken from the controller's output table.
    function automatic obs_t ref_out(input state_e st, input logic [5:0] op,
                                     input logic rdy, input logic ill);
        obs_t o;
        o    = '0;
        o.st = st;
        case (st)
            StFetch:  begin o.mrd = 1; o.srcb = 2'b01; o.irw = rdy; o.pcw = rdy; end
            StDecode: begin o.srcb = 2'b11; o.ill = ill; end
            StMemAdr: begin o.srca = 1; o.srcb = 2'b10; end
            StMemRd:  begin o.mrd = 1; o.iord = 1; end
            StMemWr:  begin o.mwr = 1; o.iord = 1; end
            StMemWb:  begin o.rw = 1; o.m2r = 1; end
            StRExec:  begin o.srca = 1; o.aluop = 2'b10; end
            StRWb:    begin o.rw = 1; o.rdst = 1; end
            StIExec:  begin o.srca = 1; o.srcb = 2'b10; o.aluop = (op == OpAndi) ? 2'b11 : 2'b00; end
            StIWb:    begin o.rw = 1; end
            StBranch: begin
                o.srca = 1; o.aluop = 2'b01; o.pcsrc = 2'b01;
                o.beq = (op == OpBeq); o.bne = (op == OpBne);
            end
            StJump:   begin o.pcw = 1; o.pcsrc = 2'b10; end
            default:  o = '0;
        endcase
        return o;
    endfunction

    // One clock cycle: drive inputs, queue the expectation, then compare once outputs settle.
    task automatic cyc(input logic rst, input logic [5:0] op, input logic rdy,
                       input state_e st, input string tag);
        obs_t e, got;
        logic ill;
        @(negedge clk);
        if (use_b) rst_b = rst; else rst_a = rst;
        opcode    = op;
        mem_ready = rdy;
        if (st == StDecode) held = op;
        ill = (st == StDecode) && !legal(op);
        exp_q.push_back(ref_out(st, held, use_b ? 1'b1 : rdy, ill));
        #1;
        got = use_b ? obs_b : obs_a;
        e   = exp_q.pop_front();
        checks++;
        assert (got === e) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, e);
        end
    endtask

    initial begin
        checks = 0; errors = 0; use_b = 1'b0; held = '0;
        rst_a = 1'b1; rst_b = 1'b1; opcode = '0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);

        // lw with ready memory; opcode input scrambled after DECODE
        cyc(0, 6'h3f, 1, StFetch,  "lw_fetch");
        cyc(0, OpLw,  1, StDecode, "lw_decode");
        cyc(0, 6'h3f, 1, StMemAdr, "lw_memadr");
        cyc(0, 6'h3f, 1, StMemRd,  "lw_memrd");
        cyc(0, 6'h3f, 1, StMemWb,  "lw_memwb");

        // sw with three wait cycles in MEMWR
        cyc(0, OpR,  1, StFetch,  "sw_fetch");
        cyc(0, OpSw, 1, StDecode, "sw_decode");
        cyc(0, OpLw, 1, StMemAdr, "sw_memadr");
        cyc(0, OpLw, 0, StMemWr,  "sw_wait1");
        cyc(0, OpLw, 0, StMemWr,  "sw_wait2");
        cyc(0, OpLw, 0, StMemWr,  "sw_wait3");
        cyc(0, OpLw, 1, StMemWr,  "sw_done");

        // beq (with one FETCH stall), then bne
        cyc(0, OpBeq, 0, StFetch,  "beq_fetch_wait");
        cyc(0, OpBeq, 1, StFetch,  "beq_fetch");
        cyc(0, OpBeq, 1, StDecode, "beq_decode");
        cyc(0, OpBne, 1, StBranch, "beq_branch");
        cyc(0, OpBne, 1, StFetch,  "bne_fetch");
        cyc(0, OpBne, 1, StDecode, "bne_decode");
        cyc(0, OpBeq, 1, StBranch, "bne_branch");

        // andi, addi, R-type, jump
        cyc(0, OpAndi, 1, StFetch,  "andi_fetch");
        cyc(0, OpAndi, 1, StDecode, "andi_decode");
        cyc(0, OpAddi, 1, StIExec,  "andi_iexec");
        cyc(0, OpAddi, 1, StIWb,    "andi_iwb");
        cyc(0, OpAddi, 1, StFetch,  "addi_fetch");
        cyc(0, OpAddi, 1, StDecode, "addi_decode");
        cyc(0, OpAndi, 1, StIExec,  "addi_iexec");
        cyc(0, OpAndi, 1, StIWb,    "addi_iwb");
        cyc(0, OpR,    1, StFetch,  "r_fetch");
        cyc(0, OpR,    1, StDecode, "r_decode");
        cyc(0, OpR,    1, StRExec,  "r_rexec");
        cyc(0, OpR,    1, StRWb,    "r_rwb");
        cyc(0, OpJ,    1, StFetch,  "j_fetch");
        cyc(0, OpJ,    1, StDecode, "j_decode");
        cyc(0, OpJ,    1, StJump,   "j_jump");

        // illegal opcode: one-cycle pulse, straight back to FETCH
        cyc(0, 6'h3f, 1, StFetch,  "ill_fetch");
        cyc(0, 6'h3f, 1, StDecode, "ill_decode");
        cyc(0, 6'h3f, 0, StFetch,  "ill_back_fetch");

        // reset while stalled in MEMRD
        cyc(0, OpLw, 1, StFetch,  "rst_fetch");
        cyc(0, OpLw, 1, StDecode, "rst_decode");
        cyc(0, OpLw, 1, StMemAdr, "rst_memadr");
        cyc(0, OpLw, 0, StMemRd,  "rst_memrd_wait");
        cyc(1, OpLw, 0, StMemRd,  "rst_memrd_reset");
        cyc(0, OpLw, 0, StFetch,  "rst_after_fetch");
        cyc(0, OpLw, 1, StFetch,  "rst_after_fetch2");

        // second DUT: handshake disabled, mem_ready held low throughout
        @(negedge clk);
        rst_a = 1'b1;
        use_b = 1'b1;
        cyc(0, OpLw, 0, StFetch,  "nohs_fetch");
        cyc(0, OpLw, 0, StDecode, "nohs_decode");
        cyc(0, OpLw, 0, StMemAdr, "nohs_memadr");
        cyc(0, OpLw, 0, StMemRd,  "nohs_memrd");
        cyc(0, OpLw, 0, StMemWb,  "nohs_memwb");
        cyc(0, OpSw, 0, StFetch,  "nohs_sw_fetch");
        cyc(0, OpSw, 0, StDecode, "nohs_sw_decode");
        cyc(0, OpSw, 0, StMemAdr, "nohs_sw_memadr");
        cyc(0, OpSw, 0, StMemWr,  "nohs_sw_memwr");
        cyc(0, OpLw, 0, StFetch,  "nohs_rst_fetch");
        cyc(0, OpLw, 0, StDecode, "nohs_rst_decode");
        cyc(0, OpLw, 0, StMemAdr, "nohs_rst_memadr");
        cyc(1, OpLw, 0, StMemRd,  "nohs_rst_memrd");
        cyc(0, OpLw, 0, StFetch,  "nohs_rst_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
